// File: rtl/packet_framer_if.sv
// rtl/packet_framer_if.sv - source and downstream FIFO handshake signals of the packet framer.
// master: source/FIFO side; slave: framer side.
interface packet_framer_if;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        fifo_prog_full;
  logic [31:0] data_out;
  logic        data_out_valid;

  modport master (
    output src_data, src_valid, fifo_prog_full,
    input  src_ready, data_out, data_out_valid
  );

  modport slave (
    input  src_data, src_valid, fifo_prog_full,
    output src_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/packet_framer.sv
// rtl/packet_framer.sv - wraps source samples into header/payload/checksum-trailer packets.
// Header is {SYNC_WORD, seq_num}; the trailer is the mod-2^32 sum of the payload words.
module packet_framer #(
  parameter int          PACKET_SIZE = 1024,
  parameter logic [15:0] SYNC_WORD   = 16'hA5A5
) (
  input  logic            data_in_clk,
  input  logic            rst,
  input  logic            enable,
  packet_framer_if.slave  bus,
  output logic [15:0]     seq_num,
  output logic            pkt_done,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

  // Counter index of the final payload word (PACKET_SIZE-2 payload words in total).
  localparam logic [10:0] LAST_IDX = 11'(PACKET_SIZE - 3);

  state_t      state;
  logic [10:0] word_cnt;
  logic [31:0] checksum;
  logic        xfer;

  assign bus.src_ready = (state == PAYLOAD) && !bus.fifo_prog_full;
  assign xfer          = bus.src_valid && bus.src_ready;
  assign busy          = (state != IDLE);

  always_ff @(posedge data_in_clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
      pkt_done           <= 1'b0;
      seq_num            <= '0;
      word_cnt           <= '0;
      checksum           <= '0;
    end else begin
      bus.data_out_valid <= 1'b0;
      pkt_done           <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) state <= HEADER;
        end
        HEADER: begin
          word_cnt <= '0;
          if (!bus.fifo_prog_full) begin
            bus.data_out       <= {SYNC_WORD, seq_num};
            bus.data_out_valid <= 1'b1;
            checksum           <= '0;
            state              <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            bus.data_out       <= bus.src_data;
            bus.data_out_valid <= 1'b1;
            checksum           <= checksum + bus.src_data;
            word_cnt           <= word_cnt + 11'd1;
            if (word_cnt == LAST_IDX) state <= TRAILER;
          end
        end
        TRAILER: begin
          if (!bus.fifo_prog_full) begin
            bus.data_out       <= checksum;
            bus.data_out_valid <= 1'b1;
            pkt_done           <= 1'b1;
            seq_num            <= seq_num + 16'd1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb/tb_packet_framer.sv - scoreboard bench for packet_framer with 8-word packets.
module tb_packet_framer;
  localparam int PS = 8;

  logic        data_in_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] seq_num;
  logic        pkt_done;
  logic        busy;

  packet_framer_if bus ();

  packet_framer #(.PACKET_SIZE(PS), .SYNC_WORD(16'hA5A5)) dut (
    .data_in_clk(data_in_clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .seq_num    (seq_num),
    .pkt_done   (pkt_done),
    .busy       (busy)
  );

  always #5 data_in_clk = ~data_in_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_seq = 16'h0000;
  logic [31:0] pay[6];
  logic [31:0] exp_sum;
  logic [31:0] mon_exp;

  // Every emitted word is matched against the expected stream in order.
  always @(negedge data_in_clk) begin
    if (!rst && bus.data_out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected word %h, no word expected", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.data_out !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard: data_out %h, expected %h", bus.data_out, mon_exp);
        end
      end
    end
  end

  task automatic push_packet(input logic [15:0] s, input int n, input bit with_trailer);
    logic [31:0] sum = 32'h0;
    exp_q.push_back({16'hA5A5, s});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pay[i]);
      sum = sum + pay[i];
    end
    if (with_trailer) exp_q.push_back(sum);
    exp_sum = sum;
  endtask

  task automatic feed(input int n, input bit gaps);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.src_valid = 1'b0;
        @(posedge data_in_clk) #1;
      end
      bus.src_valid = 1'b1;
      bus.src_data  = pay[i];
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge data_in_clk);
        if (bus.src_ready) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL feed: src_ready never 1 for word %0d, expected 1", i); end
      @(posedge data_in_clk) #1;
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge data_in_clk);
      if (pkt_done) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_header(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge data_in_clk);
      if (bus.data_out_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; bus.src_valid = 1'b0; bus.src_data = '0; bus.fifo_prog_full = 1'b0;
    repeat (2) @(posedge data_in_clk);
    #1;
    n_checks++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL reset data_out: %h, expected 0", bus.data_out); end
    n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset data_out_valid: %b, expected 0", bus.data_out_valid); end
    n_checks++; if (bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL reset src_ready: %b, expected 0", bus.src_ready); end
    n_checks++; if (pkt_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset pkt_done/busy: %b/%b, expected 0/0", pkt_done, busy); end
    n_checks++; if (seq_num !== 16'h0) begin n_fail++; $display("FAIL reset seq_num: %h, expected 0", seq_num); end
    @(negedge data_in_clk) rst = 1'b0;
    @(posedge data_in_clk) #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle without enable busy: %b, expected 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    for (int i = 0; i < 6; i++) pay[i] = 32'(i + 1);
    push_packet(exp_seq, 6, 1'b1);
    enable = 1'b1;
    fork
      feed(6, 1'b0);
      begin
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic pkt_done: not seen, expected pulse"); end
        n_checks++; if (bus.data_out !== 32'h15) begin n_fail++; $display("FAIL basic trailer: %h, expected 00000015", bus.data_out); end
        enable = 1'b0;
        @(posedge data_in_clk) #1;
        n_checks++; if (seq_num !== 16'h1) begin n_fail++; $display("FAIL basic seq_num: %h, expected 0001", seq_num); end
        n_checks++; if (pkt_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic after trailer pkt_done/busy: %b/%b, expected 0/0", pkt_done, busy); end
      end
    join
    exp_seq++;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic drain: %0d words left, expected 0", exp_q.size()); end
  endtask

  task automatic test_header_stall();
    bit ok;
    for (int i = 0; i < 6; i++) pay[i] = 32'h100 + 32'(i);
    push_packet(exp_seq, 6, 1'b1);
    bus.fifo_prog_full = 1'b1;
    enable = 1'b1;
    fork
      feed(6, 1'b0);
      begin
        @(posedge data_in_clk) #1;
        for (int k = 0; k < 5; k++) begin
          @(negedge data_in_clk);
          n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL header stall valid cycle %0d: %b, expected 0", k, bus.data_out_valid); end
          n_checks++; if (bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL header stall src_ready cycle %0d: %b, expected 0", k, bus.src_ready); end
          @(posedge data_in_clk) #1;
        end
        bus.fifo_prog_full = 1'b0;
        @(posedge data_in_clk) #1;
        n_checks++; if (bus.data_out_valid !== 1'b1 || bus.data_out !== {16'hA5A5, exp_seq}) begin
          n_fail++; $display("FAIL header release: valid %b data %h, expected 1 %h", bus.data_out_valid, bus.data_out, {16'hA5A5, exp_seq});
        end
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== exp_sum) begin n_fail++; $display("FAIL header stall trailer: %h, expected %h", bus.data_out, exp_sum); end
        enable = 1'b0;
      end
    join
    exp_seq++;
  endtask

  task automatic test_carry();
    bit ok;
    for (int i = 0; i < 6; i++) pay[i] = 32'hFFFF_FFFF;
    push_packet(exp_seq, 6, 1'b1);
    enable = 1'b1;
    fork
      feed(6, 1'b0);
      begin
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL carry trailer: %h, expected fffffffa", bus.data_out); end
        enable = 1'b0;
      end
    join
    exp_seq++;
  endtask

  task automatic test_payload_stall();
    bit ok;
    for (int i = 0; i < 6; i++) pay[i] = 32'hC0DE_0000 + 32'(i * 7);
    push_packet(exp_seq, 6, 1'b1);
    enable = 1'b1;
    fork
      feed(6, 1'b0);
      begin
        wait_header(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL payload stall header: not seen, expected header"); end
        @(posedge data_in_clk) #1;
        bus.fifo_prog_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge data_in_clk);
          n_checks++; if (bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL payload stall src_ready cycle %0d: %b, expected 0", k, bus.src_ready); end
          if (k > 0) begin
            n_checks++; if (bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL payload stall valid cycle %0d: %b, expected 0", k, bus.data_out_valid); end
          end
          @(posedge data_in_clk) #1;
        end
        bus.fifo_prog_full = 1'b0;
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== exp_sum) begin n_fail++; $display("FAIL payload stall trailer: %h, expected %h", bus.data_out, exp_sum); end
        enable = 1'b0;
      end
    join
    exp_seq++;
  endtask

  task automatic test_gaps_enable();
    bit ok;
    for (int i = 0; i < 6; i++) pay[i] = 32'h1000_0000 + 32'(i * 3);
    push_packet(exp_seq, 6, 1'b1);
    enable = 1'b1;
    fork
      feed(6, 1'b1);
      begin
        wait_header(ok);
        repeat (2) @(posedge data_in_clk);
        #1 enable = 1'b0;
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== exp_sum) begin n_fail++; $display("FAIL gaps trailer: %h, expected %h", bus.data_out, exp_sum); end
        repeat (2) begin
          @(posedge data_in_clk) #1;
          n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gaps idle busy: %b, expected 0", busy); end
        end
      end
    join
    exp_seq++;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL gaps drain: %0d words left, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] s1;
    for (int i = 0; i < 6; i++) pay[i] = $urandom;
    push_packet(exp_seq, 6, 1'b1);
    s1 = exp_sum;
    push_packet(exp_seq + 16'd1, 6, 1'b1);
    enable = 1'b1;
    fork
      begin feed(6, 1'b0); feed(6, 1'b0); end
      begin
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== s1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b first trailer: %h busy %b, expected %h busy 0", bus.data_out, busy, s1); end
        @(negedge data_in_clk);
        n_checks++; if (bus.data_out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b gap cycle: valid %b busy %b, expected 0 1", bus.data_out_valid, busy); end
        @(negedge data_in_clk);
        n_checks++; if (bus.data_out_valid !== 1'b1 || bus.data_out !== {16'hA5A5, exp_seq + 16'd1}) begin
          n_fail++; $display("FAIL b2b second header: valid %b data %h, expected 1 %h", bus.data_out_valid, bus.data_out, {16'hA5A5, exp_seq + 16'd1});
        end
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== exp_sum) begin n_fail++; $display("FAIL b2b second trailer: %h, expected %h", bus.data_out, exp_sum); end
        enable = 1'b0;
      end
    join
    exp_seq = exp_seq + 16'd2;
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 6; i++) pay[i] = 32'h5000 + 32'(i);
    push_packet(exp_seq, 3, 1'b0);
    enable = 1'b1;
    feed(3, 1'b0);
    enable = 1'b0;
    @(negedge data_in_clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.data_out !== 32'h0 || bus.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid reset data: %h valid %b, expected 0 0", bus.data_out, bus.data_out_valid); end
    n_checks++; if (busy !== 1'b0 || pkt_done !== 1'b0 || bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL mid reset busy/done/ready: %b%b%b, expected 000", busy, pkt_done, bus.src_ready); end
    n_checks++; if (seq_num !== 16'h0) begin n_fail++; $display("FAIL mid reset seq_num: %h, expected 0000", seq_num); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid reset words before reset: %0d left, expected 0", exp_q.size()); end
    @(negedge data_in_clk) rst = 1'b0;
    exp_seq = 16'h0;
    for (int i = 0; i < 6; i++) pay[i] = 32'h7700 + 32'(i);
    push_packet(exp_seq, 6, 1'b1);
    @(posedge data_in_clk) #1 enable = 1'b1;
    fork
      feed(6, 1'b0);
      begin
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== exp_sum) begin n_fail++; $display("FAIL post reset trailer: %h, expected %h", bus.data_out, exp_sum); end
        enable = 1'b0;
      end
    join
    exp_seq++;
  endtask

  task automatic test_seq_wrap();
    bit ok;
    force dut.seq_num = 16'hFFFF;
    @(posedge data_in_clk) #1;
    release dut.seq_num;
    exp_seq = 16'hFFFF;
    for (int i = 0; i < 6; i++) pay[i] = 32'hABC0 + 32'(i);
    push_packet(exp_seq, 6, 1'b1);
    enable = 1'b1;
    fork
      feed(6, 1'b0);
      begin
        wait_done(ok);
        n_checks++; if (!ok || bus.data_out !== exp_sum) begin n_fail++; $display("FAIL wrap trailer: %h, expected %h", bus.data_out, exp_sum); end
        enable = 1'b0;
        @(posedge data_in_clk) #1;
        n_checks++; if (seq_num !== 16'h0000) begin n_fail++; $display("FAIL wrap seq_num: %h, expected 0000", seq_num); end
      end
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_header_stall();
    test_carry();
    test_payload_stall();
    test_gaps_enable();
    test_back_to_back();
    test_reset_mid();
    test_seq_wrap();
    repeat (3) @(posedge data_in_clk);
    #1;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL final drain: %0d words left, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_framer.md
PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 1024: total words per packet, header and trailer included; legal range 3..2048.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hA5A5: upper half of the header word.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all logic SHALL be in the data_in_clk domain.
REQ-004 data_in_clk  input  1  single clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  permits the start of a new packet.
REQ-007 src_data  input  32  payload sample from the source.
REQ-008 src_valid  input  1  src_data is valid.
REQ-009 src_ready  output  1  framer accepts src_data this cycle.
REQ-010 fifo_prog_full  input  1  downstream FIFO is near full; stall output.
REQ-011 data_out  output  32  framed word to the downstream FIFO.
REQ-012 data_out_valid  output  1  one-cycle write strobe for data_out.
REQ-013 seq_num  output  16  sequence number of the current or last packet.
REQ-014 pkt_done  output  1  one-cycle pulse when the trailer is written.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, HEADER, PAYLOAD and TRAILER.
REQ-017 IDLE -> HEADER when enable=1; otherwise stay in IDLE.
REQ-018 HEADER: when fifo_prog_full=0, emit {SYNC_WORD, seq_num} and go to PAYLOAD; when fifo_prog_full=1, hold with no emission.
REQ-019 PAYLOAD: src_ready SHALL equal ~fifo_prog_full (combinational from registered state); a transfer occurs iff src_valid & src_ready.
REQ-020 Each payload transfer SHALL register src_data onto data_out with data_out_valid=1 on the next cycle, giving 1-cycle latency.
REQ-021 Payload word counter SHALL be 11 bits, cleared in HEADER, incremented per transfer; PAYLOAD -> TRAILER after exactly PACKET_SIZE-2 transfers.
REQ-022 Checksum SHALL be a 32-bit sum of payload words, mod 2^32 with carry discarded, cleared on header emission.
REQ-023 TRAILER: when fifo_prog_full=0, emit the checksum, pulse pkt_done, increment seq_num and go to IDLE; when fifo_prog_full=1, hold.
REQ-024 seq_num SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 data_out_valid SHALL be 0 on every cycle without an emission; data_out SHALL hold its last value.
REQ-026 src_ready SHALL be 0 in IDLE, HEADER and TRAILER.
REQ-027 Deassertion of enable outside IDLE SHALL be ignored; the current packet completes.
REQ-028 A gap in src_valid (src_valid=0) SHALL stall PAYLOAD without emitting a word or advancing the counter.
REQ-029 fifo_prog_full rising in the same cycle as src_valid=1 SHALL block that transfer; the word stays pending at the source.
REQ-030 With enable held high, back-to-back packets SHALL occur with exactly one IDLE cycle between the trailer and the next header.

Reset
REQ-031 rst=1 SHALL asynchronously force: state IDLE, data_out 0, data_out_valid 0, src_ready 0, pkt_done 0, busy 0, seq_num 0, counter 0, checksum 0.
REQ-032 Reset mid-packet SHALL abandon the partial packet with no trailer emitted; after release, the first packet SHALL carry seq_num 0.
REQ-033 Outputs SHALL leave their reset values only on the first data_in_clk edge after rst deasserts.

Verification
REQ-034 PACKET_SIZE=8, enable=1, src_valid=1 with data 1..6, fifo_prog_full=0 -> data_out sequence A5A50000,1,2,3,4,5,6,00000015; pkt_done pulses on the trailer cycle; seq_num becomes 1.
REQ-035 fifo_prog_full=1 held 5 cycles during HEADER -> no data_out_valid for those 5 cycles, header emitted on the first cycle after release, src_ready=0 throughout.
REQ-036 Payload 32'hFFFFFFFF x6 -> trailer 32'hFFFFFFFA, carry discarded.
REQ-037 seq_num preset to FFFF via 65535 packets (or forced), one more packet -> header A5A5FFFF, seq_num afterwards 0000.
REQ-038 rst pulsed after the 3rd payload word -> outputs at reset values immediately, no trailer; the next packet header is A5A50000.
REQ-039 src_valid toggling 1010... with enable dropped mid-PAYLOAD -> exactly 6 payload words, correct trailer, then IDLE with busy=0.
